// File: rtl/mac_sequencer_if.sv
// Command, operand, MAC-drive and result bundle between the MAC sequencer and its neighbours.
// master = sequencer side, slave = controller/MAC/result-consumer side.
interface mac_sequencer_if #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 24
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_mode;
    logic [7:0]       cmd_len;

    logic             op_valid;
    logic             op_ready;
    logic [IN_W-1:0]  op_a;
    logic [IN_W-1:0]  op_b;

    logic             mac_sq;
    logic             mac_sc;
    logic             mac_mat8;
    logic             mac_mat16;
    logic             mac_col_sum;
    logic [IN_W-1:0]  mac_in1;
    logic [IN_W-1:0]  mac_in2;
    logic [OUT_W-1:0] mac_out;
    logic             mac_done;

    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;
    logic [2:0]       res_mode;
    logic             res_err;

    modport master (
        input  cmd_valid, cmd_mode, cmd_len,
        input  op_valid, op_a, op_b,
        input  mac_out, mac_done,
        input  res_ready,
        output cmd_ready, op_ready,
        output mac_sq, mac_sc, mac_mat8, mac_mat16, mac_col_sum, mac_in1, mac_in2,
        output res_valid, res_data, res_mode, res_err
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_len,
        output op_valid, op_a, op_b,
        output mac_out, mac_done,
        output res_ready,
        input  cmd_ready, op_ready,
        input  mac_sq, mac_sc, mac_mat8, mac_mat16, mac_col_sum, mac_in1, mac_in2,
        input  res_valid, res_data, res_mode, res_err
    );
endinterface

// File: rtl/mac_sequencer.sv
// MAC initiator: arm mode line ARM_CYC cycles, stream pairs (1-cycle registered), capture result into a
// RES_DEPTH FIFO; cmd_ready reserves FIFO room so results never drop. Watchdog via MAC_SEQ_TIMEOUT_EN.
module mac_sequencer #(
    parameter int IN_W      = 20,
    parameter int OUT_W     = 24,
    parameter int ARM_CYC   = 2,
    parameter int RES_DEPTH = 4
`ifdef MAC_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic            clk,
    input  logic            rst,
    mac_sequencer_if.master bus,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_STREAM, S_WAIT} state_t;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [2:0]       mode;
        logic             err;
    } res_t;

    localparam int AW    = $clog2(RES_DEPTH);
    localparam int CW    = AW + 1;
    localparam int ARM_W = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;

    state_t            state, nxt;
    logic [2:0]        mode_q;
    logic [7:0]        left_q;
    logic [ARM_W-1:0]  arm_cnt;
    logic              live;

    res_t              mem [RES_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;

    logic              cmd_fire, cmd_ok, op_fire, arm_last;
    logic              done_hit, timeout_hit, push, pop;
    logic [IN_W-1:0]   in1_nxt, in2_nxt;
    res_t              push_ent;

    assign cmd_fire = bus.cmd_valid & bus.cmd_ready;
    assign cmd_ok   = (bus.cmd_mode <= 3'd4) && (bus.cmd_len != 8'd0);
    assign op_fire  = bus.op_valid & bus.op_ready;
    assign arm_last = (arm_cnt == ARM_W'(ARM_CYC - 1));
    assign done_hit = (state == S_WAIT) & bus.mac_done;
    assign push     = done_hit | timeout_hit;
    assign pop      = bus.res_valid & bus.res_ready;

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + TW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // A real mac_done on the final cycle wins over the timeout.
    assign timeout_hit = (state == S_WAIT) && !bus.mac_done && (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        push_ent      = '0;
        push_ent.data = done_hit ? bus.mac_out : '0;
        push_ent.mode = mode_q;
        push_ent.err  = timeout_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (cmd_fire && cmd_ok)          nxt = S_ARM;
            S_ARM:    if (arm_last)                    nxt = S_STREAM;
            S_STREAM: if (op_fire && left_q == 8'd1)   nxt = S_WAIT;
            S_WAIT:   if (push)                        nxt = S_IDLE;
            default:                                   nxt = S_IDLE;
        endcase
    end

    // live keeps cmd_ready low while reset is asserted even though the FSM sits in IDLE.
    always_comb begin
        bus.cmd_ready   = live && (state == S_IDLE) && (count < CW'(RES_DEPTH));
        bus.op_ready    = (state == S_STREAM);
        bus.mac_sq      = (state == S_ARM) && (mode_q == 3'd0);
        bus.mac_sc      = (state == S_ARM) && (mode_q == 3'd1);
        bus.mac_mat8    = (state == S_ARM) && (mode_q == 3'd2);
        bus.mac_mat16   = (state == S_ARM) && (mode_q == 3'd3);
        bus.mac_col_sum = (state == S_ARM) && (mode_q == 3'd4);
        busy            = (state != S_IDLE);
        bus.res_valid   = (count != '0);
        bus.res_data    = mem[rd_ptr].data;
        bus.res_mode    = mem[rd_ptr].mode;
        bus.res_err     = mem[rd_ptr].err;
        in1_nxt         = op_fire ? bus.op_a : '0;
        in2_nxt         = op_fire ? bus.op_b : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= '0;
            left_q      <= '0;
            arm_cnt     <= '0;
            live        <= 1'b0;
            bus.mac_in1 <= '0;
            bus.mac_in2 <= '0;
        end else begin
            live <= 1'b1;
            if (cmd_fire) begin
                mode_q <= bus.cmd_mode;
                left_q <= bus.cmd_len;
            end else if (op_fire) begin
                left_q <= left_q - 8'd1;
            end
            arm_cnt     <= (state == S_ARM) ? arm_cnt + ARM_W'(1) : '0;
            bus.mac_in1 <= in1_nxt;
            bus.mac_in2 <= in2_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_ent;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: results expected at mac_done time, compared when popped.
module tb_mac_sequencer;

    localparam int IN_W    = 20;
    localparam int OUT_W   = 24;
    localparam int ARM_CYC = 2;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [2:0]       mode;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    mac_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    mac_sequencer #(
        .IN_W(IN_W),
        .OUT_W(OUT_W),
        .ARM_CYC(ARM_CYC),
        .RES_DEPTH(4)
`ifdef MAC_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] mode_lines();
        return {bus.mac_col_sum, bus.mac_mat16, bus.mac_mat8, bus.mac_sc, bus.mac_sq};
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(bus.res_data), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("res_data", 32'(bus.res_data), 32'(e.data));
                chk("res_mode", 32'(bus.res_mode), 32'(e.mode));
                chk("res_err",  32'(bus.res_err),  32'(e.err));
            end
        end
    end

    task automatic set_res_ready(input logic v);
        @(posedge clk);
        #1 bus.res_ready = v;
    endtask

    // Drives one command end to end; abort_at >= 0 pulls reset after that many accepted pairs.
    task automatic run_cmd(input logic [2:0] mode, input logic [7:0] len, input int gap_at,
                           input int gap_len, input logic [OUT_W-1:0] result,
                           input int abort_at, input bit no_done);
        int              acc, gap, bud;
        logic [IN_W-1:0] exp_in;
        logic [4:0]      mexp;
        mexp = 5'd1 << mode;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = mode;
        bus.cmd_len   = len;
        bud = 0;
        while (!bus.cmd_ready && bud < 200) begin
            @(negedge clk);
            bud++;
        end
        chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        for (int c = 1; c <= ARM_CYC; c++) begin
            @(negedge clk);
            chk("arm_mode_lines", 32'(mode_lines()), 32'(mexp));
            chk("arm_busy", 32'(busy), 32'd1);
            chk("arm_op_ready", 32'(bus.op_ready), 32'd0);
            chk("arm_mac_in1", 32'(bus.mac_in1), 32'd0);
        end
        @(negedge clk);
        chk("stream_mode_lines", 32'(mode_lines()), 32'd0);
        acc = 0; gap = 0; bud = 0; exp_in = '0;
        while (acc < int'(len) && bud < 1000) begin
            chk("stream_op_ready", 32'(bus.op_ready), 32'd1);
            chk("stream_mac_in1", 32'(bus.mac_in1), 32'(exp_in));
            chk("stream_mac_in2", 32'(bus.mac_in2), 32'(exp_in));
            if (acc == abort_at) begin
                bus.op_valid = 1'b0;
                #2 rst = 1'b0;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_op_ready", 32'(bus.op_ready), 32'd0);
                chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
                chk("rst_mac_in1", 32'(bus.mac_in1), 32'd0);
                chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (acc == gap_at && gap < gap_len) begin
                bus.op_valid = 1'b0;
                exp_in = '0;
                gap++;
            end else begin
                bus.op_valid = 1'b1;
                bus.op_a = IN_W'(2 + acc);
                bus.op_b = IN_W'(2 + acc);
                exp_in   = IN_W'(2 + acc);
                acc++;
            end
            @(negedge clk);
            bud++;
        end
        bus.op_valid = 1'b0;
        chk("wait_op_ready", 32'(bus.op_ready), 32'd0);
        chk("last_pair_in1", 32'(bus.mac_in1), 32'(exp_in));
        chk("wait_busy", 32'(busy), 32'd1);
        if (!no_done) begin
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                chk("wait_mac_in1", 32'(bus.mac_in1), 32'd0);
                chk("wait_busy", 32'(busy), 32'd1);
            end
            bus.mac_done = 1'b1;
            bus.mac_out  = result;
            sb.push_back('{data: result, mode: mode, err: 1'b0});
            @(negedge clk);
            bus.mac_done = 1'b0;
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_res_valid", 32'(bus.res_valid), 32'd1);
        end
`ifdef MAC_SEQ_TIMEOUT_EN
        else begin
            sb.push_back('{data: '0, mode: mode, err: 1'b1});
            for (int j = 0; j < 15; j++) @(negedge clk);
            chk("to_busy_before", 32'(busy), 32'd1);
            @(negedge clk);
            chk("to_busy_after", 32'(busy), 32'd0);
            chk("to_res_valid", 32'(bus.res_valid), 32'd1);
            for (int j = 0; j < 3; j++) @(negedge clk);
            bus.mac_done = 1'b1;
            bus.mac_out  = 24'h00BEEF;
            @(negedge clk);
            bus.mac_done = 1'b0;
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_mode = '0; bus.cmd_len = '0;
        bus.op_valid  = 1'b0; bus.op_a = '0; bus.op_b = '0;
        bus.mac_out   = '0;   bus.mac_done = 1'b0; bus.res_ready = 1'b0;
        #1;
        chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_op_ready", 32'(bus.op_ready), 32'd0);
        chk("reset_mode_lines", 32'(mode_lines()), 32'd0);
        chk("reset_mac_in1", 32'(bus.mac_in1), 32'd0);
        chk("reset_res_valid", 32'(bus.res_valid), 32'd0);
        chk("reset_res_data", 32'(bus.res_data), 32'd0);
        chk("reset_res_err", 32'(bus.res_err), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // mat8, four back-to-back pairs; result held until consumer is ready
        run_cmd(3'd2, 8'd4, -1, 0, 24'h000036, -1, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_res_data", 32'(bus.res_data), 32'h36);
        end
        set_res_ready(1'b1);

        // two bubble cycles after the second pair
        run_cmd(3'd1, 8'd4, 2, 2, 24'h000111, -1, 1'b0);

        // fill the FIFO, then show a fifth command is held off
        set_res_ready(1'b0);
        run_cmd(3'd0, 8'd1, -1, 0, 24'h0000A1, -1, 1'b0);
        run_cmd(3'd1, 8'd2, -1, 0, 24'h0000B2, -1, 1'b0);
        run_cmd(3'd3, 8'd3, -1, 0, 24'h0000C3, -1, 1'b0);
        run_cmd(3'd4, 8'd1, -1, 0, 24'h0000D4, -1, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_mode = 3'd0; bus.cmd_len = 8'd1;
        repeat (3) begin
            @(negedge clk);
            chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("full_busy", 32'(busy), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        set_res_ready(1'b1);
        repeat (6) @(negedge clk);
        chk("drained_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("drained_sb", 32'(sb.size()), 32'd0);

        // illegal mode and zero length are swallowed
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_mode  = (k == 0) ? 3'd6 : 3'd2;
            bus.cmd_len   = (k == 0) ? 8'd3 : 8'd0;
            chk("drop_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            @(posedge clk);
            #1 bus.cmd_valid = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("drop_busy", 32'(busy), 32'd0);
                chk("drop_mode_lines", 32'(mode_lines()), 32'd0);
                chk("drop_res_valid", 32'(bus.res_valid), 32'd0);
            end
        end

        // reset mid-stream, then a clean mat16 run
        run_cmd(3'd3, 8'd5, -1, 0, 24'h0, 2, 1'b0);
        run_cmd(3'd3, 8'd3, -1, 0, 24'h0ABCDE, -1, 1'b0);

`ifdef MAC_SEQ_TIMEOUT_EN
        run_cmd(3'd4, 8'd2, -1, 0, 24'h0, -1, 1'b1);
        repeat (4) @(negedge clk);
        chk("stray_done_res_valid", 32'(bus.res_valid), 32'd0);
        chk("stray_done_busy", 32'(busy), 32'd0);
`endif

        repeat (5) @(negedge clk);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_res_valid", 32'(bus.res_valid), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
